// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Holds the FSM encoding, requester indices and default bus widths.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 32;

  localparam logic CPU    = 1'b0;
  localparam logic LOADER = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    READ   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bus of the arbiter, bundled as one interface.
// The master modport is the environment (requesters + memory); slave is the arbiter.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic [1:0]          REQ;
  logic [1:0]          WE;
  logic [2*ADDR_W-1:0] ADDR;
  logic [2*DATA_W-1:0] WDATA;
  logic [1:0]          GNT;
  logic [1:0]          RVALID;
  logic [DATA_W-1:0]   RDATA;
  logic                MEM_CS;
  logic                MEM_WE;
  logic [ADDR_W-1:0]   MEM_ADDR;
  logic [DATA_W-1:0]   MEM_WDATA;
  logic [DATA_W-1:0]   MEM_RDATA;

  modport master (
    output REQ, WE, ADDR, WDATA, MEM_RDATA,
    input  GNT, RVALID, RDATA, MEM_CS, MEM_WE, MEM_ADDR, MEM_WDATA
  );

  modport slave (
    input  REQ, WE, ADDR, WDATA, MEM_RDATA,
    output GNT, RVALID, RDATA, MEM_CS, MEM_WE, MEM_ADDR, MEM_WDATA
  );
endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the port
// that was not served last.
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       winner_o,
  output logic       any_o
);

  assign any_o    = |req_i;
  assign winner_o = (req_i == 2'b11) ? ~last_i : (req_i[LOADER] ? LOADER : CPU);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter: latch the winner in IDLE, issue it
// in ACCESS, and for reads capture the memory word in READ.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
)(
  input  logic          CLK,
  input  logic          RST_N,
  mem_arbiter_if.slave  bus
);

  state_e              state_q, state_d;
  logic                win_q, last_q, we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic [1:0]          rvalid_q;
  logic                winner, any;

  rr_pick2 u_pick (
    .req_i    (bus.REQ),
    .last_i   (last_q),
    .winner_o (winner),
    .any_o    (any)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any) state_d = ACCESS;
      ACCESS:  state_d = we_q ? IDLE : READ;
      READ:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Inputs are frozen here so requester changes after the latch cannot disturb the access.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      win_q   <= CPU;
      last_q  <= CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      if (state_q == IDLE && any) begin
        win_q   <= winner;
        we_q    <= bus.WE[winner];
        addr_q  <= winner ? bus.ADDR[2*ADDR_W-1:ADDR_W] : bus.ADDR[ADDR_W-1:0];
        wdata_q <= winner ? bus.WDATA[2*DATA_W-1:DATA_W] : bus.WDATA[DATA_W-1:0];
      end
      if (state_q == ACCESS) last_q <= win_q;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rvalid_q <= 2'b00;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= (state_q == READ) ? (2'b01 << win_q) : 2'b00;
      if (state_q == READ) rdata_q <= bus.MEM_RDATA;
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    bus.GNT    = 2'b00;
    bus.MEM_CS = 1'b0;
    bus.MEM_WE = 1'b0;
    unique case (state_q)
      ACCESS: begin
        bus.MEM_CS       = 1'b1;
        bus.MEM_WE       = we_q;
        bus.GNT[win_q]   = 1'b1;
      end
      READ:    bus.MEM_CS = 1'b1;
      default: ;
    endcase
  end

  assign bus.MEM_ADDR  = addr_q;
  assign bus.MEM_WDATA = wdata_q;
  assign bus.RVALID    = rvalid_q;
  assign bus.RDATA     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected grants/read data,
// a negedge monitor pops and compares whenever GNT or RVALID is presented.
module tb_mem_arbiter;

  logic CLK = 1'b0;
  logic RST_N;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mem_init = 1'b0;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic        port;
    logic        we;
    logic [6:0]  addr;
    logic [31:0] wdata;
    int          cyc;
  } gnt_exp_t;

  typedef struct {
    logic        port;
    logic [31:0] data;
    int          cyc;
  } rv_exp_t;

  gnt_exp_t gnt_q [$];
  rv_exp_t  rv_q  [$];
  gnt_exp_t ge;
  rv_exp_t  re;

  // Simple synchronous memory: one-cycle read latency.
  logic [31:0] mem [128];
  always @(posedge CLK) begin
    if (!mem_init) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'hA500_0000 | i;
      mem_init <= 1'b1;
    end else if (bus.MEM_CS) begin
      if (bus.MEM_WE) mem[bus.MEM_ADDR] <= bus.MEM_WDATA;
      else            bus.MEM_RDATA     <= mem[bus.MEM_ADDR];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (bus.GNT != 2'b00) begin
      if (gnt_q.size() == 0) check("unexpected_gnt", {62'd0, bus.GNT}, 64'd0);
      else begin
        ge = gnt_q.pop_front();
        check("gnt_port",  {62'd0, bus.GNT}, 64'd1 << ge.port);
        check("gnt_cycle", cyc, ge.cyc);
        check("gnt_cs",    bus.MEM_CS, 1);
        check("gnt_we",    bus.MEM_WE, ge.we);
        check("gnt_addr",  bus.MEM_ADDR, ge.addr);
        if (ge.we) check("gnt_wdata", bus.MEM_WDATA, ge.wdata);
      end
    end
    if (bus.RVALID != 2'b00) begin
      if (rv_q.size() == 0) check("unexpected_rvalid", {62'd0, bus.RVALID}, 64'd0);
      else begin
        re = rv_q.pop_front();
        check("rvalid_port",  {62'd0, bus.RVALID}, 64'd1 << re.port);
        check("rvalid_cycle", cyc, re.cyc);
        check("rdata",        bus.RDATA, re.data);
      end
    end
    if (bus.MEM_WE) check("we_only_with_gnt", bus.GNT != 2'b00, 1);
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_gnt"},    bus.GNT, 0);
    check({tag, "_rvalid"}, bus.RVALID, 0);
    check({tag, "_rdata"},  bus.RDATA, 0);
    check({tag, "_cs"},     bus.MEM_CS, 0);
    check({tag, "_we"},     bus.MEM_WE, 0);
    check({tag, "_addr"},   bus.MEM_ADDR, 0);
    check({tag, "_wdata"},  bus.MEM_WDATA, 0);
  endtask

  task automatic drive_port(input logic p, input logic we, input logic [6:0] a, input logic [31:0] wd);
    bus.WE[p]                  = we;
    bus.ADDR[int'(p)*7 +: 7]   = a;
    bus.WDATA[int'(p)*32 +: 32] = wd;
    bus.REQ[p]                 = 1'b1;
  endtask

  // Called #1 after an edge with the DUT idle at the next edge; returns in the same situation.
  task automatic do_req(input logic p, input logic we, input logic [6:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd);
    int n;
    drive_port(p, we, a, wd);
    n = cyc + 1;
    gnt_q.push_back('{port: p, we: we, addr: a, wdata: wd, cyc: n});
    if (!we) rv_q.push_back('{port: p, data: exp_rd, cyc: n + 2});
    @(posedge CLK); #1;
    bus.REQ = 2'b00;
    if (we) begin
      @(posedge CLK); #1;
    end else begin
      repeat (2) @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.REQ   = 2'b00;
    bus.WE    = 2'b00;
    bus.ADDR  = '0;
    bus.WDATA = '0;
    RST_N     = 1'b1;
    #1 RST_N  = 1'b0;
    #1 check_outputs_zero("reset");
    repeat (2) @(posedge CLK);
    #3 RST_N = 1'b1;
    @(posedge CLK); #1;

    // Tie from reset: port 1 first, then strict alternation.
    drive_port(1'b0, 1'b1, 7'h10, 32'h1111_1111);
    drive_port(1'b1, 1'b1, 7'h20, 32'h2222_2222);
    n = cyc + 1;
    gnt_q.push_back('{port: 1'b1, we: 1'b1, addr: 7'h20, wdata: 32'h2222_2222, cyc: n});
    gnt_q.push_back('{port: 1'b0, we: 1'b1, addr: 7'h10, wdata: 32'h1111_1111, cyc: n + 2});
    gnt_q.push_back('{port: 1'b1, we: 1'b1, addr: 7'h20, wdata: 32'h2222_2222, cyc: n + 4});
    gnt_q.push_back('{port: 1'b0, we: 1'b1, addr: 7'h10, wdata: 32'h1111_1111, cyc: n + 6});
    repeat (7) @(posedge CLK);
    #1 bus.REQ = 2'b00;
    @(posedge CLK); #1;

    do_req(1'b0, 1'b1, 7'h05, 32'hDEAD_BEEF, 32'h0);
    do_req(1'b1, 1'b0, 7'h05, 32'h0, 32'hDEAD_BEEF);

    // Request withdrawn before the arbitration edge: no access at all.
    drive_port(1'b0, 1'b0, 7'h07, 32'h0);
    #3 bus.REQ = 2'b00;
    repeat (3) begin
      @(negedge CLK);
      check("withdraw_cs", bus.MEM_CS, 0);
    end
    @(posedge CLK); #1;

    do_req(1'b0, 1'b0, 7'h01, 32'h0, 32'hA500_0001);
    do_req(1'b0, 1'b0, 7'h02, 32'h0, 32'hA500_0002);
    do_req(1'b0, 1'b0, 7'h10, 32'h0, 32'h1111_1111);
    do_req(1'b1, 1'b0, 7'h20, 32'h0, 32'h2222_2222);

    // Reset asserted mid-READ: only the grant is expected, never the read data.
    drive_port(1'b1, 1'b0, 7'h03, 32'h0);
    n = cyc + 1;
    gnt_q.push_back('{port: 1'b1, we: 1'b0, addr: 7'h03, wdata: 32'h0, cyc: n});
    @(posedge CLK); #1;
    bus.REQ = 2'b00;
    @(posedge CLK); #2;
    RST_N = 1'b0;
    #1 check_outputs_zero("abort");
    @(posedge CLK);
    #3 RST_N = 1'b1;
    repeat (4) @(posedge CLK);
    #1;

    // Last-served pointer must be back at port 0, so port 1 wins this tie.
    drive_port(1'b0, 1'b1, 7'h30, 32'h3333_3333);
    drive_port(1'b1, 1'b1, 7'h31, 32'h4444_4444);
    n = cyc + 1;
    gnt_q.push_back('{port: 1'b1, we: 1'b1, addr: 7'h31, wdata: 32'h4444_4444, cyc: n});
    gnt_q.push_back('{port: 1'b0, we: 1'b1, addr: 7'h30, wdata: 32'h3333_3333, cyc: n + 2});
    repeat (3) @(posedge CLK);
    #1 bus.REQ = 2'b00;
    @(posedge CLK); #1;

    do_req(1'b0, 1'b0, 7'h05, 32'h0, 32'hDEAD_BEEF);
    do_req(1'b1, 1'b0, 7'h31, 32'h0, 32'h4444_4444);
    do_req(1'b0, 1'b0, 7'h30, 32'h0, 32'h3333_3333);

    repeat (5) @(posedge CLK);
    #1;
    check("gnt_queue_drained", gnt_q.size(), 0);
    check("rv_queue_drained",  rv_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
